jtag_dbg_cmd_sysclk_dec: RTL and testbench

- Parametrised system-clock-side command decoder for the on-chip JTAG debug port; next generation of the fixed 2-bit-IR / 38-bit-DR decoder.
- Receives the TCK-domain instruction (ir_in), shift-register snapshot (sr) and update strobes (vs_uir, vs_udr) as asynchronous levels.
- Synchronises the strobes, captures the command and emits per-channel one-cycle take_action / take_no_action pulses.
- Adds features the old decoder lacks: per-channel busy/ack handshake, overrun detection, and a post-reset arming window.

---
 rtl/jtag_dbg_pkg.sv | 20 ++
 rtl/jtag_dbg_sync_edge.sv | 31 +++
 rtl/jtag_dbg_cmd_sysclk_dec.sv | 131 +++++++++++++
 tb/tb_jtag_dbg_cmd_sysclk_dec.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_dbg_pkg.sv
// Shared defaults and index helpers for the system-clock-side JTAG debug command decoder.
package jtag_dbg_pkg;

  localparam int unsigned IR_W_DEF        = 2;
  localparam int unsigned DR_W_DEF        = 38;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  function automatic int unsigned num_ch(input int unsigned ir_w);
    return 1 << ir_w;
  endfunction

  function automatic int unsigned action_bit_idx(input int unsigned dr_w);
    return dr_w - 1;
  endfunction

  function automatic int unsigned parity_bit_idx(input int unsigned dr_w);
    return dr_w - 2;
  endfunction

endpackage

// File: rtl/jtag_dbg_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level followed by rising-edge detection.
module jtag_dbg_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/jtag_dbg_cmd_sysclk_dec.sv
// System-clock-side JTAG debug command decoder with per-channel busy/ack and overrun tracking.
// Define JTAG_DBG_CMD_PARITY_EN to enable the even-parity check on sr[DR_W-2].
module jtag_dbg_cmd_sysclk_dec
  import jtag_dbg_pkg::*;
#(
  parameter int unsigned IR_W        = IR_W_DEF,
  parameter int unsigned DR_W        = DR_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  localparam int unsigned NUM_CH     = num_ch(IR_W)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [IR_W-1:0]   ir_in,
  input  logic [DR_W-1:0]   sr,
  input  logic              vs_uir,
  input  logic              vs_udr,
  input  logic [NUM_CH-1:0] cmd_ack,
  input  logic              overrun_clr,
  output logic [DR_W-1:0]   jdo,
  output logic [IR_W-1:0]   ir_q,
  output logic [NUM_CH-1:0] take_action,
  output logic [NUM_CH-1:0] take_no_action,
  output logic [NUM_CH-1:0] busy,
  output logic              overrun,
  output logic              parity_err
);

  localparam int unsigned ACT_IDX = action_bit_idx(DR_W);
  localparam int unsigned ARM_MAX = SYNC_STAGES + 1;
  localparam int unsigned ARM_W   = $clog2(ARM_MAX + 1);
  localparam logic [ARM_W-1:0] ARM_SAT = ARM_W'(ARM_MAX);

  logic              uir_rise, udr_rise, armed, parity_bad, drop;
  logic [ARM_W-1:0]  arm_q, arm_d;
  logic              uir_evt_q, uir_evt_d, udr_evt_q, udr_evt_d;
  logic [IR_W-1:0]   ir_latch_q, ir_latch_d;
  logic [DR_W-1:0]   jdo_q, jdo_d;
  logic [NUM_CH-1:0] busy_q, busy_d, busy_ack;
  logic [NUM_CH-1:0] take_action_q, take_action_d, take_no_action_q, take_no_action_d;
  logic              overrun_q, overrun_d, parity_err_q, parity_err_d;

  jtag_dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
    .clk        (clk),
    .reset_n    (reset_n),
    .async_in   (vs_uir),
    .rise_pulse (uir_rise)
  );

  jtag_dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
    .clk        (clk),
    .reset_n    (reset_n),
    .async_in   (vs_udr),
    .rise_pulse (udr_rise)
  );

`ifdef JTAG_DBG_CMD_PARITY_EN
  localparam int unsigned PAR_IDX = parity_bit_idx(DR_W);
  assign parity_bad = sr[PAR_IDX] ^ (^sr[PAR_IDX-1:0]);
`else
  assign parity_bad = 1'b0;
`endif

  // Edges seen before the counter saturates belong to strobes already high at reset release.
  assign armed = (arm_q == ARM_SAT);

  always_comb begin
    arm_d            = armed ? arm_q : arm_q + ARM_W'(1);
    uir_evt_d        = uir_rise & armed;
    udr_evt_d        = udr_rise & armed;
    ir_latch_d       = uir_evt_q ? ir_in : ir_latch_q;
    busy_ack         = busy_q & ~cmd_ack;
    busy_d           = busy_ack;
    jdo_d            = jdo_q;
    take_action_d    = '0;
    take_no_action_d = '0;
    parity_err_d     = 1'b0;
    drop             = 1'b0;
    // Decode uses the pre-update ir_latch_q, so a same-cycle UIR lands afterwards.
    if (udr_evt_q) begin
      if (parity_bad) begin
        parity_err_d = 1'b1;
      end else if (busy_ack[ir_latch_q]) begin
        drop = 1'b1;
      end else begin
        jdo_d = sr;
        if (sr[ACT_IDX]) begin
          take_action_d[ir_latch_q] = 1'b1;
          busy_d[ir_latch_q]        = 1'b1;
        end else begin
          take_no_action_d[ir_latch_q] = 1'b1;
        end
      end
    end
    overrun_d = drop | (overrun_q & ~overrun_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_q            <= '0;
      uir_evt_q        <= 1'b0;
      udr_evt_q        <= 1'b0;
      ir_latch_q       <= '0;
      jdo_q            <= '0;
      busy_q           <= '0;
      take_action_q    <= '0;
      take_no_action_q <= '0;
      overrun_q        <= 1'b0;
      parity_err_q     <= 1'b0;
    end else begin
      arm_q            <= arm_d;
      uir_evt_q        <= uir_evt_d;
      udr_evt_q        <= udr_evt_d;
      ir_latch_q       <= ir_latch_d;
      jdo_q            <= jdo_d;
      busy_q           <= busy_d;
      take_action_q    <= take_action_d;
      take_no_action_q <= take_no_action_d;
      overrun_q        <= overrun_d;
      parity_err_q     <= parity_err_d;
    end
  end

  assign jdo            = jdo_q;
  assign ir_q           = ir_latch_q;
  assign take_action    = take_action_q;
  assign take_no_action = take_no_action_q;
  assign busy           = busy_q;
  assign overrun        = overrun_q;
  assign parity_err     = parity_err_q;

endmodule

// File: tb/tb_jtag_dbg_cmd_sysclk_dec.sv
// Directed-vector bench for jtag_dbg_cmd_sysclk_dec at IR_W=2, DR_W=38, SYNC_STAGES=2.
module tb_jtag_dbg_cmd_sysclk_dec;

  localparam int unsigned SYNC = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        vs_uir, vs_udr;
  logic [3:0]  cmd_ack;
  logic        overrun_clr;
  logic [37:0] jdo;
  logic [1:0]  ir_q;
  logic [3:0]  take_action, take_no_action, busy;
  logic        overrun, parity_err;

  int n_vec = 0;
  int n_bad = 0;

  jtag_dbg_cmd_sysclk_dec #(
    .IR_W        (2),
    .DR_W        (38),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ir_in          (ir_in),
    .sr             (sr),
    .vs_uir         (vs_uir),
    .vs_udr         (vs_udr),
    .cmd_ack        (cmd_ack),
    .overrun_clr    (overrun_clr),
    .jdo            (jdo),
    .ir_q           (ir_q),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .busy           (busy),
    .overrun        (overrun),
    .parity_err     (parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Fill in the parity bit when the parity check is built in, so ordinary vectors stay valid.
  function automatic logic [37:0] fix_par(input logic [37:0] v);
    logic [37:0] r;
    r = v;
`ifdef JTAG_DBG_CMD_PARITY_EN
    r[36] = ^v[35:0];
`endif
    return r;
  endfunction

  task automatic strobe_uir(input logic [1:0] ir);
    @(negedge clk);
    ir_in  = ir;
    vs_uir = 1'b1;
    repeat (SYNC + 3) @(posedge clk);
    #1;
    check("uir_ir_q", 64'(ir_q), 64'(ir));
    @(negedge clk);
    vs_uir = 1'b0;
    repeat (SYNC + 2) @(posedge clk);
  endtask

  task automatic udr_cmd(input string tag, input logic [37:0] data, input logic [3:0] exp_act,
                         input logic [3:0] exp_noact, input logic exp_perr,
                         input logic [3:0] ack_evt, input logic raise_uir,
                         input logic [1:0] new_ir);
    @(negedge clk);
    sr     = data;
    vs_udr = 1'b1;
    if (raise_uir) begin
      ir_in  = new_ir;
      vs_uir = 1'b1;
    end
    repeat (SYNC + 1) @(posedge clk);
    #1;
    check({tag, "_early"}, 64'({take_action, take_no_action, parity_err}), 64'd0);
    cmd_ack = ack_evt;
    @(posedge clk);
    #1;
    cmd_ack = '0;
    check({tag, "_act"}, 64'(take_action), 64'(exp_act));
    check({tag, "_noact"}, 64'(take_no_action), 64'(exp_noact));
    check({tag, "_perr"}, 64'(parity_err), 64'(exp_perr));
    @(posedge clk);
    #1;
    check({tag, "_once"}, 64'({take_action, take_no_action, parity_err}), 64'd0);
    @(negedge clk);
    vs_udr = 1'b0;
    vs_uir = 1'b0;
    repeat (SYNC + 2) @(posedge clk);
  endtask

  task automatic ack(input logic [3:0] a);
    @(negedge clk);
    cmd_ack = a;
    @(negedge clk);
    cmd_ack = '0;
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      seen = seen | (|take_action) | (|take_no_action) | parity_err;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    reset_n     = 1'b0;
    ir_in       = '0;
    sr          = fix_par(38'h20_0000_0055);
    vs_uir      = 1'b0;
    vs_udr      = 1'b1;
    cmd_ack     = '0;
    overrun_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", 64'({take_action, take_no_action, busy, overrun, parity_err, ir_q}), 64'd0);
    check("rst_jdo", 64'(jdo), 64'd0);

    // vs_udr high across reset release must never fire.
    @(negedge clk);
    reset_n = 1'b1;
    watch_quiet("arm_hold", 12);
    @(negedge clk);
    vs_udr = 1'b0;
    repeat (SYNC + 2) @(posedge clk);
    udr_cmd("arm_first", fix_par(38'h00_0000_0055), 4'b0000, 4'b0001, 1'b0, 4'b0000, 1'b0, 2'd0);
    check("arm_jdo", 64'(jdo), 64'(fix_par(38'h00_0000_0055)));

    // Basic action decode on channel 1, then acknowledge.
    strobe_uir(2'b01);
    udr_cmd("basic", fix_par(38'h20_0000_00AB), 4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);
    check("basic_jdo", 64'(jdo), 64'(fix_par(38'h20_0000_00AB)));
    check("basic_busy", 64'(busy), 64'h2);
    ack(4'b0010);
    #1;
    check("basic_ack", 64'(busy), 64'h0);
    ack(4'b0100);
    check("ack_idle", 64'(busy), 64'h0);

    // No-action path on channel 3.
    strobe_uir(2'b11);
    udr_cmd("noact", fix_par(38'h0_1234_5678), 4'b0000, 4'b1000, 1'b0, 4'b0000, 1'b0, 2'd0);
    check("noact_busy", 64'(busy), 64'h0);
    check("noact_jdo", 64'(jdo), 64'(fix_par(38'h0_1234_5678)));

    // Overrun on channel 0, then ack and a new command in the same cycle.
    strobe_uir(2'b00);
    udr_cmd("ovr_a", fix_par(38'h20_0000_0001), 4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);
    check("ovr_a_busy", 64'(busy), 64'h1);
    check("ovr_a_flag", 64'(overrun), 64'h0);
    udr_cmd("ovr_b", fix_par(38'h20_0000_0002), 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);
    check("ovr_b_jdo", 64'(jdo), 64'(fix_par(38'h20_0000_0001)));
    check("ovr_b_flag", 64'(overrun), 64'h1);
    udr_cmd("ovr_c", fix_par(38'h20_0000_0003), 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 2'd0);
    check("ovr_c_jdo", 64'(jdo), 64'(fix_par(38'h20_0000_0003)));
    check("ovr_c_busy", 64'(busy), 64'h1);
    check("ovr_c_flag", 64'(overrun), 64'h1);
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("ovr_clr", 64'(overrun), 64'h0);
    ack(4'b0001);
    check("ovr_ack", 64'(busy), 64'h0);

    // UIR and UDR rising together: decode with old ir_q=0, then ir_q=2.
    udr_cmd("simul", fix_par(38'h0_0000_0C3C), 4'b0000, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd2);
    check("simul_ir", 64'(ir_q), 64'h2);

`ifdef JTAG_DBG_CMD_PARITY_EN
    // Odd parity over [35:0] with bit36=0 is rejected; correct parity decodes normally.
    udr_cmd("par_bad", 38'h00_0000_0001, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0);
    check("par_bad_jdo", 64'(jdo), 64'(fix_par(38'h0_0000_0C3C)));
    check("par_bad_flags", 64'({busy, overrun}), 64'h0);
    udr_cmd("par_ok", 38'h10_0000_0001, 4'b0000, 4'b0100, 1'b0, 4'b0000, 1'b0, 2'd0);
    check("par_ok_jdo", 64'(jdo), 64'h10_0000_0001);
`endif

    // Busy on channel 2, then reset in the middle of a pending strobe.
    udr_cmd("pre_rst", fix_par(38'h20_0000_0077), 4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);
    check("pre_rst_busy", 64'(busy), 64'h4);
    @(negedge clk);
    sr     = fix_par(38'h20_0000_0099);
    vs_udr = 1'b1;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_outs", 64'({take_action, take_no_action, busy, overrun, parity_err, ir_q}),
          64'd0);
    check("mid_rst_jdo", 64'(jdo), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    watch_quiet("mid_rst_arm", 12);
    @(negedge clk);
    vs_udr = 1'b0;
    repeat (SYNC + 2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
